// File: rtl/life_scheduler_pkg.sv
// Shared types and helpers for the generation scheduler.
package life_scheduler_pkg;

    localparam int unsigned LOG_MAX_SPEED = 3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_COMPUTE,
        S_WAIT_SWAP
    } sched_state_t;

    // Timer reload for a period of (base >> speed); a period that shifts to zero runs every cycle.
    function automatic int unsigned reload_value(input int unsigned base,
                                                 input logic [LOG_MAX_SPEED-1:0] speed);
        int unsigned period;
        period = base >> speed;
        return (period == 0) ? 0 : period - 1;
    endfunction

endpackage

// File: rtl/life_scheduler_rate_timer.sv
// Free-running generation-rate down-counter with a one-bit sticky tick flag.
module life_scheduler_rate_timer
    import life_scheduler_pkg::*;
#(
    parameter int unsigned BASE_PERIOD = 1_000_000
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic [LOG_MAX_SPEED-1:0] speed_in,
    input  logic                     clear_in,
    output logic                     tick_pending_out
);

    localparam int unsigned CNT_W = (BASE_PERIOD > 1) ? $clog2(BASE_PERIOD) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] reload;
    logic             at_zero;

    assign reload  = CNT_W'(reload_value(BASE_PERIOD, speed_in));
    assign at_zero = (cnt_q == '0);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cnt_q            <= reload;
            tick_pending_out <= 1'b0;
        end else begin
            cnt_q <= at_zero ? reload : cnt_q - 1'b1;
            // A tick landing on the clear cycle wins so it is not lost.
            if (at_zero) begin
                tick_pending_out <= 1'b1;
            end else if (clear_in) begin
                tick_pending_out <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/life_scheduler.sv
// Sequences life_logic generations and commits the double-buffer swap on vsync only.
module life_scheduler
    import life_scheduler_pkg::*;
#(
    parameter int unsigned BASE_PERIOD = 1_000_000,
    parameter int unsigned GEN_W       = 16
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     run_in,
    input  logic                     step_in,
    input  logic [LOG_MAX_SPEED-1:0] speed_in,
    input  logic                     vsync_in,
    input  logic                     logic_done_in,
    output logic                     logic_start_out,
    output logic                     buf_sel_out,
    output logic                     busy_out,
    output logic [GEN_W-1:0]         gen_count_out
);

    sched_state_t state_q;
    logic         tick_pending;
    logic         clear_pending;

    assign clear_pending = (state_q == S_START);

    life_scheduler_rate_timer #(
        .BASE_PERIOD(BASE_PERIOD)
    ) u_rate_timer (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .speed_in        (speed_in),
        .clear_in        (clear_pending),
        .tick_pending_out(tick_pending)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q         <= S_IDLE;
            logic_start_out <= 1'b0;
            buf_sel_out     <= 1'b0;
            busy_out        <= 1'b0;
            gen_count_out   <= '0;
        end else begin
            logic_start_out <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if ((run_in && tick_pending) || (!run_in && step_in)) begin
                        state_q  <= S_START;
                        busy_out <= 1'b1;
                    end
                end
                S_START: begin
                    logic_start_out <= 1'b1;
                    state_q         <= S_COMPUTE;
                end
                // vsync is deliberately not looked at here, so a coincident frame start is skipped.
                S_COMPUTE: begin
                    if (logic_done_in) begin
                        state_q <= S_WAIT_SWAP;
                    end
                end
                S_WAIT_SWAP: begin
                    if (vsync_in) begin
                        buf_sel_out   <= ~buf_sel_out;
                        gen_count_out <= gen_count_out + 1'b1;
                        busy_out      <= 1'b0;
                        state_q       <= S_IDLE;
                    end
                end
                default: begin
                    state_q  <= S_IDLE;
                    busy_out <= 1'b0;
                end
            endcase
        end
    end

endmodule
